// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states,
// grant owner encoding and the latched memory command.
package mem_arb_pkg;

  // Command struct width; the arbiter's DataWidth must match this value.
  localparam int unsigned ARB_DW = 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

  typedef struct packed {
    logic              we_re;
    logic [3:0]        mask;
    logic [ARB_DW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } arb_cmd_t;

  // Data port wins unless fetch is waiting and has already been passed over too often.
  function automatic arb_gnt_t arb_pick(input logic d_req, input logic i_req,
                                        input logic starved);
    return (d_req && (!i_req || !starved)) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and load/store (D)
// ports; D has priority, a starvation counter forces fetch progress, a timeout aborts hung accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataWidth  = ARB_DW,
  parameter int unsigned MaxDBurst  = 4,
  parameter int unsigned TimeoutCyc = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic                 i_we_re,
  input  logic [3:0]           i_mask,
  input  logic [DataWidth-1:0] i_addr,
  output logic                 i_valid,
  output logic [DataWidth-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we_re,
  input  logic [3:0]           d_mask,
  input  logic [DataWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_valid,
  output logic [DataWidth-1:0] d_rdata,
  output logic                 mem_req,
  output logic                 mem_we_re,
  output logic [3:0]           mem_mask,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_valid,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 err
);

  localparam int unsigned SW = (MaxDBurst  < 2) ? 1 : $clog2(MaxDBurst + 1);
  localparam int unsigned TW = (TimeoutCyc < 2) ? 1 : $clog2(TimeoutCyc + 1);
  localparam logic [SW-1:0] MAX_D    = SW'(MaxDBurst);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCyc - 1);

  arb_state_t r_state, w_state_nxt;
  arb_gnt_t   r_gnt, w_gnt;
  arb_cmd_t   r_cmd, w_cmd_in;
  logic       w_grant, w_done, w_abort;

  logic [SW-1:0]        r_starve_cnt;
  logic [TW-1:0]        r_tmo_cnt;
  logic                 r_mem_req, r_i_valid, r_d_valid, r_err;
  logic [DataWidth-1:0] r_i_rdata, r_d_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_gnt       = arb_pick(d_req, i_req, r_starve_cnt == MAX_D);
    w_cmd_in    = (w_gnt == GNT_D) ? {d_we_re, d_mask, d_addr, d_wdata}
                                   : {i_we_re, i_mask, i_addr, {ARB_DW{1'b0}}};
    case (r_state)
      IDLE: if (d_req || i_req) begin
        w_grant     = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: if (mem_valid) begin
        w_done      = 1'b1;
        w_state_nxt = RESP;
      end else if (r_tmo_cnt == TMO_LAST) begin
        w_abort     = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt        <= GNT_I;
      r_cmd        <= '0;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_mem_req    <= 1'b0;
      r_i_valid    <= 1'b0;
      r_d_valid    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == BUSY);
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= (r_state == BUSY) ? r_tmo_cnt + 1'b1 : '0;

      if (w_grant) begin
        r_gnt <= w_gnt;
        r_cmd <= w_cmd_in;
        if (w_gnt == GNT_I)
          r_starve_cnt <= '0;
        else if (i_req && (r_starve_cnt != MAX_D))
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      // Response goes only to the owner; an aborted access returns zero data.
      if (w_done || w_abort) begin
        r_err <= w_abort;
        if (r_gnt == GNT_D) begin
          r_d_valid <= 1'b1;
          r_d_rdata <= w_done ? mem_rdata : '0;
        end else begin
          r_i_valid <= 1'b1;
          r_i_rdata <= w_done ? mem_rdata : '0;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we_re = r_cmd.we_re;
  assign mem_mask  = r_cmd.mask;
  assign mem_addr  = r_cmd.addr;
  assign mem_wdata = r_cmd.wdata;
  assign i_valid   = r_i_valid;
  assign i_rdata   = r_i_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention/starvation,
// timeout abort, reset mid-access and stale memory responses.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        i_req, i_we_re, i_valid;
  logic [3:0]  i_mask;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we_re, d_valid;
  logic [3:0]  d_mask;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we_re, mem_valid, err;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.DataWidth(32), .MaxDBurst(4), .TimeoutCyc(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we_re(i_we_re), .i_mask(i_mask), .i_addr(i_addr),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   mem_req,   0);
    chk({tag, "_mem_we_re"}, mem_we_re, 0);
    chk({tag, "_mem_mask"},  mem_mask,  0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_i_valid"},   i_valid,   0);
    chk({tag, "_i_rdata"},   i_rdata,   0);
    chk({tag, "_d_valid"},   d_valid,   0);
    chk({tag, "_d_rdata"},   d_rdata,   0);
    chk({tag, "_err"},       err,       0);
  endtask

  initial begin
    bit exp_d[6];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    i_req = 0; i_we_re = 0; i_mask = 0; i_addr = 0;
    d_req = 0; d_we_re = 0; d_mask = 0; d_addr = 0; d_wdata = 0;
    mem_valid = 0; mem_rdata = 0;
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b1;

    // Lone fetch, memory answers two cycles after mem_req rises
    i_req = 1; i_we_re = 0; i_mask = 4'hF; i_addr = 32'h100;
    step();
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_mem_we_re", mem_we_re, 0);
    chk("fetch_mem_wdata", mem_wdata, 0);
    step();
    chk("fetch_mem_req_hold", mem_req, 1);
    step();
    chk("fetch_mem_req_hold2", mem_req, 1);
    mem_valid = 1; mem_rdata = 32'h00000013;
    step();
    mem_valid = 0; mem_rdata = 0;
    chk("fetch_i_valid", i_valid, 1);
    chk("fetch_i_rdata", i_rdata, 32'h13);
    chk("fetch_d_valid", d_valid, 0);
    chk("fetch_err", err, 0);
    chk("fetch_mem_req_drop", mem_req, 0);
    i_req = 0;
    step();
    chk("fetch_i_valid_pulse", i_valid, 0);
    chk("fetch_i_rdata_clr", i_rdata, 0);

    // Store, zero-wait memory; fetch command wiggles while not granted
    d_req = 1; d_we_re = 1; d_mask = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    step();
    i_addr = 32'h777;
    chk("store_mem_req", mem_req, 1);
    chk("store_mem_we_re", mem_we_re, 1);
    chk("store_mem_mask", mem_mask, 4'hF);
    chk("store_mem_addr", mem_addr, 32'h2000);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    mem_valid = 1;
    step();
    mem_valid = 0;
    chk("store_d_valid", d_valid, 1);
    chk("store_i_valid", i_valid, 0);
    chk("store_err", err, 0);
    chk("store_mem_addr_stable", mem_addr, 32'h2000);
    d_req = 0;
    step();
    chk("store_d_valid_pulse", d_valid, 0);

    // Contention: both held, zero-wait memory -> D,D,D,D,I,D
    i_req = 1; i_we_re = 0; i_mask = 4'h3; i_addr = 32'h100;
    d_req = 1; d_we_re = 0; d_mask = 4'hC; d_addr = 32'h4000; d_wdata = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("cont%0d_mem_req", k), mem_req, 1);
      chk($sformatf("cont%0d_mem_addr", k), mem_addr, exp_d[k] ? 32'h4000 : 32'h100);
      chk($sformatf("cont%0d_mem_wdata", k), mem_wdata, exp_d[k] ? 32'h12345678 : 32'h0);
      mem_valid = 1; mem_rdata = 32'hA0 + k;
      step();
      mem_valid = 0; mem_rdata = 0;
      chk($sformatf("cont%0d_d_valid", k), d_valid, exp_d[k]);
      chk($sformatf("cont%0d_i_valid", k), i_valid, !exp_d[k]);
      chk($sformatf("cont%0d_rdata", k), exp_d[k] ? d_rdata : i_rdata, 32'hA0 + k);
      step();
      chk($sformatf("cont%0d_idle", k), mem_req, 0);
      if (k == 5) begin
        i_req = 0; d_req = 0;
      end
    end

    // Timeout: memory never answers
    d_req = 1; d_we_re = 0; d_mask = 4'hF; d_addr = 32'h3000; mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("tmo_busy%0d_mem_req", k), mem_req, 1);
    end
    step();
    chk("tmo_mem_req_drop", mem_req, 0);
    chk("tmo_d_valid", d_valid, 1);
    chk("tmo_err", err, 1);
    chk("tmo_d_rdata", d_rdata, 0);
    chk("tmo_i_valid", i_valid, 0);
    d_req = 0; mem_rdata = 0;
    step();
    chk("tmo_err_pulse", err, 0);
    chk("tmo_d_valid_pulse", d_valid, 0);

    // Reset while BUSY, then a late memory response
    d_req = 1; d_we_re = 1; d_mask = 4'h1; d_addr = 32'h5000; d_wdata = 32'h99;
    step();
    chk("rstbusy_mem_req", mem_req, 1);
    rst = 0;
    #1;
    chk("rstbusy_async_mem_req", mem_req, 0);
    d_req = 0;
    step();
    rst = 1;
    mem_valid = 1; mem_rdata = 32'h5555;
    step();
    mem_valid = 0; mem_rdata = 0;
    chk_all_zero("rstlate");
    step();
    chk("rstlate2_d_valid", d_valid, 0);
    chk("rstlate2_mem_req", mem_req, 0);
    i_req = 1; i_addr = 32'h600; i_mask = 4'hF;
    step();
    chk("rst_regrant_mem_req", mem_req, 1);
    chk("rst_regrant_mem_addr", mem_addr, 32'h600);
    mem_valid = 1; mem_rdata = 32'h77;
    step();
    mem_valid = 0; mem_rdata = 0;
    chk("rst_regrant_i_valid", i_valid, 1);
    chk("rst_regrant_i_rdata", i_rdata, 32'h77);
    i_req = 0;
    step();

    // Stale mem_valid in IDLE with no request
    mem_valid = 1; mem_rdata = 32'hBAD;
    step();
    chk("stale_mem_req", mem_req, 0);
    chk("stale_i_valid", i_valid, 0);
    chk("stale_d_valid", d_valid, 0);
    step();
    chk("stale2_mem_req", mem_req, 0);
    chk("stale2_d_valid", d_valid, 0);
    chk("stale2_i_valid", i_valid, 0);
    mem_valid = 0; mem_rdata = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
